fft_bfly_r2_pipe: RTL and testbench



---
 rtl/fft_pkg.sv | 37 +++
 rtl/fft_cmul_q15.sv | 41 ++++
 rtl/ksa_top_16b.sv | 43 ++++
 rtl/fft_bfly_r2_pipe.sv | 99 +++++++++
 tb/tb_fft_bfly_r2_pipe.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types, Q1.15 constants and saturation/output-fit helpers for the radix-2 FFT datapath.
package fft_pkg;

  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [32:0] re;
    logic signed [32:0] im;
  } cprod_t;

  localparam logic signed [32:0] Q15_RND = 33'sd16384;
  localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q15_MIN = 16'sh8000;

  function automatic logic [15:0] q15_sat18(logic signed [17:0] v);
    if (v > 18'sd32767) begin
      return Q15_MAX;
    end else if (v < -18'sd32768) begin
      return Q15_MIN;
    end
    return v[15:0];
  endfunction

  // r is the 17-bit signed add/sub result; scaling is an arithmetic shift by one.
  function automatic logic [15:0] q15_fit(logic [16:0] r, logic scale);
    if (scale) begin
      return r[16:1];
    end
    return q15_sat18({r[16], r});
  endfunction

endpackage

// File: rtl/fft_cmul_q15.sv
// Q1.15 complex multiply T = W*B with optional round-half-up, saturation and one register stage.
module fft_cmul_q15 import fft_pkg::*; #(
  parameter bit RND_EN = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en_i,
  input  cplx_t b_i,
  input  cplx_t w_i,
  output cplx_t t_o
);

  logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [32:0] rnd;
  cprod_t acc;
  cplx_t  t_d, t_q;

  assign rnd = RND_EN ? Q15_RND : '0;

  always_comb begin
    p_rr   = 32'(b_i.re) * 32'(w_i.re);
    p_ii   = 32'(b_i.im) * 32'(w_i.im);
    p_ri   = 32'(b_i.re) * 32'(w_i.im);
    p_ir   = 32'(b_i.im) * 32'(w_i.re);
    acc.re = {p_rr[31], p_rr} - {p_ii[31], p_ii} + rnd;
    acc.im = {p_ri[31], p_ri} + {p_ir[31], p_ir} + rnd;
    t_d.re = q15_sat18(18'(acc.re >>> 15));
    t_d.im = q15_sat18(18'(acc.im >>> 15));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= '0;
    end else if (en_i) begin
      t_q <= t_d;
    end
  end

  assign t_o = t_q;

endmodule

// File: rtl/ksa_top_16b.sv
// 16-bit Kogge-Stone adder with carry-in and carry-out.
module ksa_top_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c0,
  output logic [15:0] s,
  output logic        c16
);

  logic [4:0][15:0] g;
  logic [3:0][15:0] p;

  // Carry-in is folded into bit 0's generate so the prefix tree only carries g/p.
  always_comb begin
    g = '0;
    p = '0;
    g[0] = a & b;
    p[0] = a ^ b;
    g[0][0] = g[0][0] | (p[0][0] & c0);
    for (int unsigned k = 1; k < 4; k++) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (i >= (32'd1 << (k - 1))) begin
          g[k][i] = g[k-1][i] | (p[k-1][i] & g[k-1][i - (32'd1 << (k - 1))]);
          p[k][i] = p[k-1][i] & p[k-1][i - (32'd1 << (k - 1))];
        end else begin
          g[k][i] = g[k-1][i];
          p[k][i] = p[k-1][i];
        end
      end
    end
    for (int unsigned i = 0; i < 16; i++) begin
      if (i >= 8) begin
        g[4][i] = g[3][i] | (p[3][i] & g[3][i - 8]);
      end else begin
        g[4][i] = g[3][i];
      end
    end
  end

  assign s   = p[0] ^ {g[4][14:0], c0};
  assign c16 = g[4][15];

endmodule

// File: rtl/fft_bfly_r2_pipe.sv
// Three-stage radix-2 DIT butterfly: X = A + W*B, Y = A - W*B, global-stall valid/ready pipeline.
module fft_bfly_r2_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter bit          RND_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_scale,
  input  logic [DATA_W-1:0] a_re,
  input  logic [DATA_W-1:0] a_im,
  input  logic [DATA_W-1:0] b_re,
  input  logic [DATA_W-1:0] b_im,
  input  logic [DATA_W-1:0] w_re,
  input  logic [DATA_W-1:0] w_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] x_re,
  output logic [DATA_W-1:0] x_im,
  output logic [DATA_W-1:0] y_re,
  output logic [DATA_W-1:0] y_im
);
  import fft_pkg::*;

  logic  adv;
  logic  v1_q, v2_q, v3_q, sc1_q, sc2_q;
  cplx_t a1_q, b1_q, w1_q, a2_q, t2, x_d, y_d, x_q, y_q;

  logic [3:0][15:0] ksa_a, ksa_b, ksa_s, fit;
  logic [3:0]       ksa_c0, ksa_c16;

  // Whole pipe advances together; bubbles are kept in place rather than collapsed.
  assign in_ready = !v3_q || out_ready;
  assign adv      = in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      sc1_q <= 1'b0;
      sc2_q <= 1'b0;
      a1_q  <= '0;
      b1_q  <= '0;
      w1_q  <= '0;
      a2_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else if (adv) begin
      v1_q  <= in_valid;
      sc1_q <= in_scale;
      a1_q  <= {a_re, a_im};
      b1_q  <= {b_re, b_im};
      w1_q  <= {w_re, w_im};
      v2_q  <= v1_q;
      sc2_q <= sc1_q;
      a2_q  <= a1_q;
      v3_q  <= v2_q;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  fft_cmul_q15 #(.RND_EN(RND_EN)) u_cmul (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (adv),
    .b_i   (b1_q),
    .w_i   (w1_q),
    .t_o   (t2)
  );

  // Lanes: 0 = X.re, 1 = X.im, 2 = Y.re, 3 = Y.im; Y subtracts via ~T with carry-in 1.
  assign ksa_a  = {a2_q.im, a2_q.re, a2_q.im, a2_q.re};
  assign ksa_b  = {~t2.im, ~t2.re, t2.im, t2.re};
  assign ksa_c0 = 4'b1100;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    ksa_top_16b u_ksa (
      .a   (ksa_a[i]),
      .b   (ksa_b[i]),
      .c0  (ksa_c0[i]),
      .s   (ksa_s[i]),
      .c16 (ksa_c16[i])
    );
    assign fit[i] = q15_fit({ksa_a[i][15] ^ ksa_b[i][15] ^ ksa_c16[i], ksa_s[i]}, sc2_q);
  end

  assign x_d = {fit[0], fit[1]};
  assign y_d = {fit[2], fit[3]};

  assign out_valid = v3_q;
  assign x_re      = x_q.re;
  assign x_im      = x_q.im;
  assign y_re      = y_q.re;
  assign y_im      = y_q.im;

endmodule

// File: tb/tb_fft_bfly_r2_pipe.sv
// Directed-vector, reset, backpressure and random-stall bench for fft_bfly_r2_pipe.
module tb_fft_bfly_r2_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_scale, out_valid, out_ready;
  logic [15:0] a_re, a_im, b_re, b_im, w_re, w_im, x_re, x_im, y_re, y_im;
  logic [63:0] dut_out;

  always #5 clk = ~clk;

  fft_bfly_r2_pipe #(.DATA_W(16), .RND_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_scale(in_scale),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im)
  );

  assign dut_out = {x_re, x_im, y_re, y_im};

  typedef struct {
    string       name;
    logic [15:0] ar, ai, br, bi, wr, wi;
    logic        sc;
    logic [15:0] xr, xi, yr, yi;
  } vec_t;

  typedef struct packed {
    logic [15:0] xr, xi, yr, yi;
  } res_t;

  int   checks = 0, failures = 0, received = 0;
  bit   mon_en = 1'b0, hold_pend = 1'b0, done = 1'b0;
  res_t held;
  res_t exp_q[$];
  vec_t vecs[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(string n, logic [15:0] ar, ai, br, bi, wr, wi, logic sc,
                              logic [15:0] xr, xi, yr, yi);
    vec_t v;
    v.name = n; v.ar = ar; v.ai = ai; v.br = br; v.bi = bi; v.wr = wr; v.wi = wi;
    v.sc = sc; v.xr = xr; v.xi = xi; v.yr = yr; v.yi = yi;
    return v;
  endfunction

  function automatic longint sx(logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [15:0] sat(longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  function automatic logic [15:0] outf(longint v, logic sc);
    if (sc) return 16'(v >>> 1);
    return sat(v);
  endfunction

  function automatic res_t model(logic [15:0] ar, ai, br, bi, wr, wi, logic sc);
    longint tr, ti;
    tr = sx(br) * sx(wr) - sx(bi) * sx(wi) + 16384;
    ti = sx(br) * sx(wi) + sx(bi) * sx(wr) + 16384;
    tr = sx(sat(tr >>> 15));
    ti = sx(sat(ti >>> 15));
    return {outf(sx(ar) + tr, sc), outf(sx(ai) + ti, sc),
            outf(sx(ar) - tr, sc), outf(sx(ai) - ti, sc)};
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rnd_in();
    a_re = pick16(); a_im = pick16(); b_re = pick16(); b_im = pick16();
    w_re = pick16(); w_im = pick16(); in_scale = 1'($urandom_range(0, 1));
  endtask

  task automatic send();
    bit acc = 1'b0;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    a_re = v.ar; a_im = v.ai; b_re = v.br; b_im = v.bi; w_re = v.wr; w_im = v.wi;
    in_scale = v.sc;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk({v.name, "_early"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({v.name, "_valid"}, 64'(out_valid), 64'd1);
    chk({v.name, "_xy"}, dut_out, {v.xr, v.xi, v.yr, v.yi});
  endtask

  // Streaming scoreboard: expectations are pushed on input transfers, popped on output transfers.
  always @(negedge clk) begin
    if (mon_en) begin
      if (in_valid && in_ready)
        exp_q.push_back(model(a_re, a_im, b_re, b_im, w_re, w_im, in_scale));
      if (hold_pend) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", dut_out, held);
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        held      = dut_out;
        hold_pend = 1'b1;
      end else begin
        hold_pend = 1'b0;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
          end else begin
            chk("stream_data", dut_out, exp_q.pop_front());
          end
          received++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk("real_unit",   16'h2000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 16'h4000, 16'h0000, 16'h0000, 16'h0000);
    vecs[1]  = mk("real_unit_s", 16'h2000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 16'h2000, 16'h0000, 16'h0000, 16'h0000);
    vecs[2]  = mk("imag_tw",     16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h7FFF, 1'b0, 16'h0000, 16'h4000, 16'h0000, 16'hC000);
    vecs[3]  = mk("imag_tw_s",   16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 16'h0000, 16'h2000, 16'h0000, 16'hE000);
    vecs[4]  = mk("wb_neg1",     16'h7FFF, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
    vecs[5]  = mk("wb_neg1_s",   16'h7FFF, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
    vecs[6]  = mk("wb_neg1_a0",  16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 16'h0000, 16'h8001, 16'h0000);
    vecs[7]  = mk("neg_sat",     16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 16'hFFFE, 16'h0000, 16'h8000, 16'h0000);
    vecs[8]  = mk("neg_sat_s",   16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 16'hFFFF, 16'h0000, 16'h8001, 16'h0000);
    vecs[9]  = mk("rnd_tie",     16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    vecs[10] = mk("rnd_down",    16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h4001, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000);
    vecs[11] = mk("cplx_mix",    16'h1000, 16'h1000, 16'h2000, 16'h2000, 16'h4000, 16'h4000, 1'b0, 16'h1000, 16'h3000, 16'h1000, 16'hF000);
    vecs[12] = mk("scale_odd",   16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF);

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_scale = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_xy", dut_out, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    out_ready = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset with three sets in flight: outputs clear at once, next set takes the full latency.
    a_re = 16'h1234; a_im = 16'h0101; b_re = 16'h2000; b_im = 16'h0000;
    w_re = 16'h7FFF; w_im = 16'h0000; in_scale = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_xy", dut_out, 64'd0);
    chk("rst_async_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(vecs[2]);
    @(posedge clk); #1;
    chk("rst_no_stale", 64'(out_valid), 64'd0);

    // Backpressure: eight back-to-back sets, output held off for five cycles after it appears.
    exp_q.delete();
    hold_pend = 1'b0; received = 0; out_ready = 1'b0; mon_en = 1'b1;
    fork
      begin
        for (int n = 0; n < 8; n++) begin
          rnd_in();
          send();
        end
      end
      begin
        for (int t = 0; t < 50 && !out_valid; t++) begin
          @(posedge clk); #1;
        end
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    for (int t = 0; t < 100 && received < 8; t++) @(posedge clk);
    chk("bp_count", 64'(received), 64'd8);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Random regression with random bubbles and output stalls.
    received = 0; done = 1'b0;
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          rnd_in();
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    for (int t = 0; t < 200 && received < 10000; t++) @(posedge clk);
    #1;
    chk("rand_count", 64'(received), 64'd10000);
    chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
